arith_add_seq: RTL and testbench
================================

Name: arith_add_seq

Overview:
- Arithmetic-side client of the dual-port operand RAM; it drives the RAM's arith port (addr_arith, data_arith, we_arith, q_arith).
- The HPS configures it over a small Avalon-MM CSR slave with source A base, source B base, destination base, length and mode, then writes start.
- Per word it reads A[i] and B[i], adds them, and writes the sum to D[i].
- Two add modes: elementwise modulo 2^DATA_W, or one multi-word add with carry chained LS word first.

Parameters:
- ADDR_W, 11, RAM word-address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, RAM and CSR data width.
- ID_WORD, 32'h41444431, constant returned at CSR 6.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  CSR word address.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- writedata  in  DATA_W  CSR write data.
- readdata  out  DATA_W  CSR read data; registered.
- addr_arith  out  ADDR_W  RAM arith-port address.
- data_arith  out  DATA_W  RAM arith-port write data.
- we_arith  out  1  RAM arith-port write enable.
- q_arith  in  DATA_W  RAM arith-port read data, valid one clock after its address is presented.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM to IDLE; all CSRs, index, carry and readdata to 0.
  - addr_arith=0, data_arith=0, we_arith=0.
  - Reset mid-operation aborts immediately; no further RAM writes occur.
- CSR map (Avalon, 0 wait states):
  - 0 CTRL/STAT. Write: bit0 start, bit1 chain. Read: bit0 busy, bit1 done, bit2 carry_out.
  - 1 A_BASE, 2 B_BASE, 3 D_BASE: ADDR_W bits; readback zero-extended.
  - 4 LEN: ADDR_W+1 bits, range 0..2048.
  - 5 COUNT: words written so far; read-only.
  - 6 ID_WORD; 7 reads 0.
- CSR read/write timing:
  - readdata is updated on the clock after read is asserted and holds its value otherwise.
  - Writes to CSRs 1-4 or to CSR 0 while busy are ignored.
  - Simultaneous read and write: the read returns the pre-write value.
- start (write to CSR 0 with bit0=1 while idle):
  - Latches chain; clears done, COUNT, carry and index i.
  - If LEN=0: done=1 on the next cycle, no RAM access.
  - Otherwise enter RDA.
- FSM, 3 clocks per word, with outputs registered on entry to each state:
  - RDA: addr_arith=A_BASE+i, we_arith=0.
  - RDB: addr_arith=B_BASE+i; q_arith now holds A[i], captured into opa at the end of RDB.
  - WR: q_arith holds B[i].
    - sum = opa + q_arith + (chain ? carry : 0), computed DATA_W+1 wide.
    - data_arith = sum[DATA_W-1:0]; addr_arith = D_BASE+i; we_arith=1 for exactly this cycle.
    - carry <= sum[DATA_W] only when chain=1; otherwise carry stays 0.
    - i and COUNT increment.
    - If i+1 = LEN go to IDLE and set done=1 (sticky until the next start), else go to RDA.
- Result: N words take 3N clocks from the first RDA to the return to IDLE; busy=1 in RDA, RDB and WR.
- Address wrap: base+i wraps modulo 2^ADDR_W; no error is flagged.
- Overlap: D=A or D=B (in place) is correct because each word's operands are read before its write. Partial overlaps with an offset are undefined by design; software must avoid them.
- Arith-port exclusivity: the CSR/HPS side must not write RAM via the Avalon port while busy. The block does not arbitrate.

Decomposition:
- Shared package arith_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the CSR index constants (CSR_CTRL=0 .. CSR_ID=6);
  - CTRL bit positions;
  - the FSM state enum {IDLE, RDA, RDB, WR}.
- One natural sub-module, arith_add_csr: the Avalon register file and readdata mux. The FSM and datapath stay in the top module.

Test Plan:
- Elementwise add:
  - Setup: A_BASE=0 holding {1,2,3,0xFFFFFFFF}, B_BASE=16 holding {10,20,30,2}, D_BASE=32, LEN=4, chain=0, start.
  - Required: D={11,22,33,1}; exactly 4 we_arith pulses at 3-clock spacing; done=1 and COUNT=4 after 12 clocks; carry_out=0.
- Chained add:
  - Setup: A={0xFFFFFFFF,0xFFFFFFFF}, B={1,0}, LEN=2, chain=1.
  - Required: D={0,0}, carry_out=1.
- LEN=0:
  - Stimulus: start.
  - Required: done=1 on the next clock; we_arith never asserted; busy pulse is at most 1 cycle.
- In place with address wrap:
  - Setup: A_BASE=D_BASE=2046, B_BASE=100, LEN=3.
  - Required: writes land at 2046, 2047, 0 with correct sums; the RAM holding A is updated in place.
- Busy protection:
  - Stimulus: mid-run, write LEN=1 and start again.
  - Required: both ignored; the run completes its original length; CSR 4 readback is unchanged.
- Reset mid-run:
  - Stimulus: assert reset in the second WR cycle.
  - Required: we_arith drops asynchronously; all CSRs read 0 afterwards; ID reads 0x41444431.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic add sequencer: widths, CSR map, CTRL bits, FSM states.
package arith_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [31:0] DEF_ID_WORD = 32'h41444431;

  // CSR word addresses
  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_A_BASE = 3'd1;
  localparam logic [2:0] CSR_B_BASE = 3'd2;
  localparam logic [2:0] CSR_D_BASE = 3'd3;
  localparam logic [2:0] CSR_LEN    = 3'd4;
  localparam logic [2:0] CSR_COUNT  = 3'd5;
  localparam logic [2:0] CSR_ID     = 3'd6;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CHAIN = 1;
  // CTRL read (status) bits
  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_CARRY = 2;

  // FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RDA  = 2'd1;
  localparam logic [1:0] RDB  = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

endpackage

// File: rtl/arith_add_csr.sv
// Avalon-MM register file for the add sequencer: base/length registers, start decode and
// registered readdata mux.
module arith_add_csr
  import arith_pkg::*;
#(
  parameter int unsigned       ADDR_W  = DEF_ADDR_W,
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] ID_WORD = DEF_ID_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  // status from the sequencer
  input  logic              busy,
  input  logic              done,
  input  logic              carry,
  input  logic [ADDR_W:0]   count,
  // configuration to the sequencer
  output logic              start,
  output logic              chain,
  output logic [ADDR_W-1:0] a_base,
  output logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] d_base,
  output logic [ADDR_W:0]   len
);

  logic              wr_ok;
  logic [DATA_W-1:0] rd_mux;

  // All configuration is frozen while a run is in progress.
  assign wr_ok = write && !busy;
  assign start = wr_ok && (address == CSR_CTRL) && writedata[CTRL_START];
  assign chain = writedata[CTRL_CHAIN];

  // Configuration register writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_base <= '0;
      b_base <= '0;
      d_base <= '0;
      len    <= '0;
    end else if (wr_ok) begin
      case (address)
        CSR_A_BASE: a_base <= writedata[ADDR_W-1:0];
        CSR_B_BASE: b_base <= writedata[ADDR_W-1:0];
        CSR_D_BASE: d_base <= writedata[ADDR_W-1:0];
        CSR_LEN:    len    <= writedata[ADDR_W:0];
        default: ;
      endcase
    end
  end

  // Read mux; sampled before any same-cycle write lands
  always_comb begin
    rd_mux = '0;
    case (address)
      CSR_CTRL: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_DONE]  = done;
        rd_mux[STAT_CARRY] = carry;
      end
      CSR_A_BASE: rd_mux[ADDR_W-1:0] = a_base;
      CSR_B_BASE: rd_mux[ADDR_W-1:0] = b_base;
      CSR_D_BASE: rd_mux[ADDR_W-1:0] = d_base;
      CSR_LEN:    rd_mux[ADDR_W:0]   = len;
      CSR_COUNT:  rd_mux[ADDR_W:0]   = count;
      CSR_ID:     rd_mux             = ID_WORD;
      default:    rd_mux             = '0;
    endcase
  end

  // Registered readdata, held between reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/arith_add_seq.sv
// Arith-port client of the operand RAM: D[i] = A[i] + B[i], elementwise or as one
// multi-word add with the carry chained LS word first. Three clocks per word.
module arith_add_seq
  import arith_pkg::*;
#(
  parameter int unsigned       ADDR_W  = DEF_ADDR_W,
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] ID_WORD = DEF_ID_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] addr_arith,
  output logic [DATA_W-1:0] data_arith,
  output logic              we_arith,
  input  logic [DATA_W-1:0] q_arith
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_next;
  logic [ADDR_W:0]   count;
  logic              carry;
  logic              done;
  logic              chain_q;
  logic [DATA_W-1:0] opa;
  logic [DATA_W:0]   sum;
  logic              busy;

  logic              start;
  logic              chain;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] d_base;
  logic [ADDR_W:0]   len;

  arith_add_csr #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ID_WORD (ID_WORD)
  ) u_csr (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata),
    .busy      (busy),
    .done      (done),
    .carry     (carry),
    .count     (count),
    .start     (start),
    .chain     (chain),
    .a_base    (a_base),
    .b_base    (b_base),
    .d_base    (d_base),
    .len       (len)
  );

  assign busy     = (state != IDLE);
  assign idx_next = idx + CNT_ONE;

  // B[i] only arrives on q_arith during WR, so the sum and write data are formed
  // combinationally in that cycle; zero elsewhere so reset forces data_arith low.
  always_comb begin
    sum = {1'b0, opa} + {1'b0, q_arith} + {{DATA_W{1'b0}}, chain_q & carry};
    data_arith = (state == WR) ? sum[DATA_W-1:0] : '0;
  end

  // Sequencer FSM with registered RAM address/write-enable and status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      carry      <= 1'b0;
      done       <= 1'b0;
      chain_q    <= 1'b0;
      opa        <= '0;
      addr_arith <= '0;
      we_arith   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_arith <= 1'b0;
          if (start) begin
            chain_q <= chain;
            count   <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              done       <= 1'b0;
              state      <= RDA;
              addr_arith <= a_base;
            end
          end
        end
        RDA: begin
          state      <= RDB;
          addr_arith <= b_base + idx[ADDR_W-1:0];
        end
        RDB: begin
          opa        <= q_arith;
          state      <= WR;
          addr_arith <= d_base + idx[ADDR_W-1:0];
          we_arith   <= 1'b1;
        end
        WR: begin
          we_arith <= 1'b0;
          idx      <= idx_next;
          count    <= count + CNT_ONE;
          carry    <= chain_q ? sum[DATA_W] : 1'b0;
          if (idx_next == len) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state      <= RDA;
            addr_arith <= a_base + idx_next[ADDR_W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_add_seq.sv
// Self-checking bench for arith_add_seq: behavioural RAM plus a word-level add model.
module tb_arith_add_seq;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 2048;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic [AW-1:0] addr_arith;
  logic [DW-1:0] data_arith;
  logic          we_arith;
  logic [DW-1:0] q_arith = '0;

  arith_add_seq dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .addr_arith (addr_arith),
    .data_arith (data_arith),
    .we_arith   (we_arith),
    .q_arith    (q_arith)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic          exp_carry;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int run_pulses = 0;
  int last_pulse = 0;

  // RAM with one-clock read latency
  always @(posedge clock) begin
    q_arith <= mem[addr_arith];
    if (we_arith) mem[addr_arith] <= data_arith;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every write pulse must be the next expected (addr, data) at 3-clock spacing
  always @(negedge clock) begin
    if (!reset && we_arith) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write_addr", {21'b0, addr_arith}, 32'hFFFF_FFFF);
      end else begin
        chk("write_addr", {21'b0, addr_arith}, {21'b0, exp_addr_q.pop_front()});
        chk("write_data", data_arith, exp_data_q.pop_front());
      end
      if (run_pulses > 0) chk("write_spacing", cyc - last_pulse, 3);
      last_pulse = cyc;
      run_pulses = run_pulses + 1;
    end
  end

  // Word-level model of one run; updates the expected memory in program order
  task automatic model_run(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d, input int len, input logic ch);
    logic [DW:0]   s;
    logic          c;
    logic [AW-1:0] da;
    c = 1'b0;
    for (int k = 0; k < len; k++) begin
      s = {1'b0, exp_mem[a + AW'(k)]} + {1'b0, exp_mem[b + AW'(k)]} + {32'b0, c};
      da = d + AW'(k);
      exp_mem[da] = s[DW-1:0];
      exp_addr_q.push_back(da);
      exp_data_q.push_back(s[DW-1:0]);
      c = ch ? s[DW] : 1'b0;
    end
    exp_carry = c;
  endtask

  // Callers are always at a negedge; tasks return at a negedge
  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic setup(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input int len, input logic ch);
    csr_write(3'd1, {21'b0, a});
    csr_write(3'd2, {21'b0, b});
    csr_write(3'd3, {21'b0, d});
    csr_write(3'd4, len);
    model_run(a, b, d, len, ch);
    run_pulses = 0;
  endtask

  task automatic start_run(input logic ch);
    csr_write(3'd0, {30'b0, ch, 1'b1});
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    r = 32'h1;
    for (int t = 0; t < 300 && r[0]; t++) csr_read(3'd0, r);
    chk("idle_wait_busy", {31'b0, r[0]}, 32'h0);
  endtask

  task automatic finish_check(input string tag, input logic [AW-1:0] d, input int len);
    logic [31:0] r;
    int bad;
    wait_idle();
    csr_read(3'd0, r);
    chk({tag, "_status"}, r, {29'b0, exp_carry, 2'b10});
    csr_read(3'd5, r);
    chk({tag, "_count"}, r, len);
    chk({tag, "_pulses"}, run_pulses, len);
    chk({tag, "_pending"}, exp_addr_q.size(), 0);
    bad = 0;
    for (int k = 0; k < len; k++) if (mem[d + AW'(k)] !== exp_mem[d + AW'(k)]) bad++;
    chk({tag, "_mem"}, bad, 0);
  endtask

  task automatic load(input logic [AW-1:0] ad, input logic [DW-1:0] v);
    mem[ad] = v;
    exp_mem[ad] = v;
  endtask

  initial begin
    logic [31:0] r;
    logic [AW-1:0] ra, rb, rd;
    int rl;
    logic rc;

    for (int i = 0; i < DEPTH; i++) load(AW'(i), $urandom);

    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_we", {31'b0, we_arith}, 32'h0);
    chk("rst_addr", {21'b0, addr_arith}, 32'h0);
    chk("rst_data", data_arith, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Elementwise add with exact timing
    load(11'd0, 32'd1); load(11'd1, 32'd2); load(11'd2, 32'd3); load(11'd3, 32'hFFFF_FFFF);
    load(11'd16, 32'd10); load(11'd17, 32'd20); load(11'd18, 32'd30); load(11'd19, 32'd2);
    setup(11'd0, 11'd16, 11'd32, 4, 1'b0);
    start_run(1'b0);
    repeat (11) @(negedge clock);
    csr_read(3'd0, r);
    chk("elem_busy_at_12", r, 32'h1);
    csr_read(3'd0, r);
    chk("elem_done_after_12", r, 32'h2);
    finish_check("elem", 11'd32, 4);
    chk("elem_d0", mem[32], 32'd11);
    chk("elem_d1", mem[33], 32'd22);
    chk("elem_d2", mem[34], 32'd33);
    chk("elem_d3", mem[35], 32'd1);

    // Chained multi-word add
    load(11'd40, 32'hFFFF_FFFF); load(11'd41, 32'hFFFF_FFFF);
    load(11'd50, 32'd1); load(11'd51, 32'd0);
    setup(11'd40, 11'd50, 11'd60, 2, 1'b1);
    start_run(1'b1);
    finish_check("chain", 11'd60, 2);
    chk("chain_d0", mem[60], 32'd0);
    chk("chain_d1", mem[61], 32'd0);
    chk("chain_carry_lit", {31'b0, exp_carry}, 32'h1);

    // LEN=0: done immediately, no RAM traffic, carry cleared
    setup(11'd0, 11'd0, 11'd0, 0, 1'b0);
    start_run(1'b0);
    csr_read(3'd0, r);
    chk("len0_status", r, 32'h2);
    repeat (4) @(negedge clock);
    chk("len0_pulses", run_pulses, 0);
    csr_read(3'd5, r);
    chk("len0_count", r, 32'h0);

    // In place with address wrap
    load(11'd2046, 32'd5); load(11'd2047, 32'd6); load(11'd0, 32'd7);
    load(11'd100, 32'd100); load(11'd101, 32'd200); load(11'd102, 32'd300);
    setup(11'd2046, 11'd100, 11'd2046, 3, 1'b0);
    start_run(1'b0);
    finish_check("wrap", 11'd2046, 3);
    chk("wrap_2046", mem[2046], 32'd105);
    chk("wrap_2047", mem[2047], 32'd206);
    chk("wrap_0", mem[0], 32'd307);

    // Busy protection: LEN rewrite and restart ignored mid-run
    setup(11'd200, 11'd600, 11'd1200, 5, 1'b0);
    start_run(1'b0);
    repeat (2) @(negedge clock);
    csr_write(3'd4, 32'd1);
    csr_write(3'd0, 32'h1);
    csr_read(3'd4, r);
    chk("busy_len_readback", r, 32'd5);
    finish_check("busy", 11'd1200, 5);
    csr_read(3'd4, r);
    chk("busy_len_after", r, 32'd5);

    // Randomized runs: disjoint regions or exact in-place, occasionally wrapping
    for (int n = 0; n < 8; n++) begin
      rl = $urandom_range(1, 20);
      rc = 1'(($urandom >> 3) & 1);
      ra = (n % 3 == 0) ? AW'($urandom_range(1990, 2047)) : AW'($urandom_range(0, 400));
      rb = AW'($urandom_range(512, 900));
      rd = (n % 2 == 0) ? ra : AW'($urandom_range(1024, 1500));
      setup(ra, rb, rd, rl, rc);
      start_run(rc);
      finish_check("rand", rd, rl);
    end

    // Reset during the second WR cycle
    setup(11'd300, 11'd700, 11'd1300, 4, 1'b0);
    start_run(1'b0);
    repeat (5) @(negedge clock);
    chk("pre_reset_we", {31'b0, we_arith}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("reset_we_async", {31'b0, we_arith}, 32'h0);
    chk("reset_data_async", data_arith, 32'h0);
    exp_addr_q.delete();
    exp_data_q.delete();
    chk("reset_pulses", run_pulses, 2);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("reset_no_more_writes", run_pulses, 2);
    for (int c = 0; c < 8; c++) begin
      csr_read(3'(c), r);
      chk($sformatf("post_reset_csr%0d", c), r, (c == 6) ? 32'h41444431 : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
